weight_skew_buffer: RTL
=======================

# weight_skew_buffer

Double-buffered, parametrised weight feeder for the systolic array's top edge. Weights for the next tile are written into a shadow bank while the active bank streams into `COLS` columns with a one-cycle-per-column diagonal skew. It replaces file-preloaded per-column weight FIFOs with a runtime-loadable, ping-pong store, and adds a programmable stream length and a reverse-order mode.

## Interface
- `COLS`, 4: systolic columns; one memory lane per column.
- `W_BITWIDTH`, 8: weight word width.
- `DEPTH`, 16: rows per bank per column.
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  reset: asynchronous, active-low.
- `wr_en`  in  1  write strobe into the shadow bank.
- `wr_col`  in  $clog2(COLS)  target column lane.
- `wr_addr`  in  $clog2(DEPTH)  row address.
- `wr_data`  in  W_BITWIDTH  weight word.
- `wr_commit`  in  1  marks the shadow bank full and hands it to the reader.
- `wr_ready`  out  1  shadow bank is empty and writable.
- `start`  in  1  request to stream the active bank.
- `len`  in  $clog2(DEPTH+1)  rows to stream; sampled on accepted `start`.
- `rev`  in  1  1 = stream rows `len-1` down to 0; sampled on accepted `start`.
- `busy`  out  1  stream in progress.
- `done`  out  1  one-cycle pulse at the end of a stream.
- `o_valid`  out  COLS  per-column valid.
- `o_data`  out  COLS×W_BITWIDTH  per-column weight; zero when the matching `o_valid` bit is 0.

## Operation
- Two banks, each holding `COLS`×`DEPTH` words. Pointers `wr_bank` and `rd_bank` both reset to 0. Per-bank `full` flags reset to 0.
- `wr_ready` = !full[wr_bank].
- A write occurs when `wr_en` && `wr_ready` && `wr_addr` < DEPTH; otherwise the write is ignored.
- A commit is accepted when `wr_commit` && `wr_ready`. It sets full[wr_bank] and toggles `wr_bank`. `wr_en` and `wr_commit` in the same cycle: the write lands first, then the commit.
- FSM states:
  - IDLE → STREAM on `start` && full[rd_bank] && 1 ≤ `len` ≤ DEPTH. Otherwise `start` is ignored.
  - STREAM issues one row per cycle to lane 0. After `len` rows → DRAIN.
  - DRAIN lasts COLS-1 cycles, then → DONE.
  - DONE lasts one cycle: pulses `done`, clears full[rd_bank], toggles `rd_bank`, → IDLE.
- Lane j replays lane 0's read address and valid delayed by j cycles. This is a per-lane shift register of valid and address, not a data skew.
- `start` while not IDLE is ignored.
- A commit and DONE in the same cycle on different banks are both honoured. If DONE frees the bank `wr_bank` points to, `wr_ready` rises the following cycle.
- Memory contents are not reset. Only flags, pointers, the FSM and the skew pipeline are reset.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `busy`=0, `done`=0, `wr_ready`=1.
- Reset asserted mid-stream clears all valids and `busy` immediately (asynchronously) and empties both banks.
- Read latency is 1: with `start` accepted at edge k, `o_valid[0]`=1 for cycles k+1 … k+len. `o_valid[j]` is high for cycles k+1+j … k+len+j.
- `busy` is high from cycle k+1 through the DONE cycle inclusive.
- `done` is high in cycle k+len+COLS, the cycle after the last `o_valid[COLS-1]`.
- Back-to-back streams: the earliest next accepted `start` is in the `done` cycle+1 (IDLE). Gap between streams ≥ COLS cycles on lane 0.
- Row order: `rev`=0 gives rows 0,1,…,len-1. `rev`=1 gives rows len-1,…,0.

## Test plan
- **Load and forward stream.** COLS=4, DEPTH=8. Load bank 0 with lane j row r = 16·j+r, commit, `start` with len=8, rev=0 at edge 10. Required: `o_data[0]`=0..7 in cycles 11..18, `o_data[3]`=48..55 in cycles 14..21, `done` at cycle 22, `wr_ready`=1 throughout.
- **Reverse stream, partial length.** Same data, len=5, rev=1. Required: lane 0 shows 4,3,2,1,0; lane 2 shows 36..32 two cycles later; `o_data` is 0 whenever valid is low.
- **Ping-pong and backpressure.** Commit bank 0 and bank 1. Required: `wr_ready`=0 and further writes ignored. After stream 0's `done`, `wr_ready`=1 next cycle. A second `start` streams bank 1's data.
- **Illegal starts.** `start` with no committed bank, len=0, len=9, or while busy. Required: no valid, `busy` stays unchanged, no pointer change.
- **Reset mid-stream.** Deassert `rstn` at cycle 3 of a stream. Required: `o_valid`=0 and `busy`=0 immediately, `wr_ready`=1. After release, `start` is ignored until a new commit.
- **Simultaneous write and commit.** Same-cycle `wr_en` and `wr_commit`. Required: the final word is present in the stream output.

Source files
------------

// File: rtl/weight_skew_buffer_if.sv
// Write-side and stream-side signal bundle for the double-buffered weight skew buffer.
// The master drives loads and stream requests; the slave is the buffer itself.
interface weight_skew_buffer_if #(
    parameter int unsigned COLS       = 4,
    parameter int unsigned W_BITWIDTH = 8,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic                                 wr_en;
    logic [CW-1:0]                        wr_col;
    logic [AW-1:0]                        wr_addr;
    logic [W_BITWIDTH-1:0]                wr_data;
    logic                                 wr_commit;
    logic                                 wr_ready;
    logic                                 start;
    logic [LW-1:0]                        len;
    logic                                 rev;
    logic                                 busy;
    logic                                 done;
    logic [COLS-1:0]                      o_valid;
    logic [COLS-1:0][W_BITWIDTH-1:0]      o_data;

    modport master (
        output wr_en, wr_col, wr_addr, wr_data, wr_commit, start, len, rev,
        input  wr_ready, busy, done, o_valid, o_data
    );

    modport slave (
        input  wr_en, wr_col, wr_addr, wr_data, wr_commit, start, len, rev,
        output wr_ready, busy, done, o_valid, o_data
    );
endinterface

// File: rtl/weight_skew_buffer.sv
// Ping-pong weight store feeding the systolic array's top edge: the shadow bank is loaded
// while the active bank streams rows to lane 0, with lane j replaying lane 0 j cycles later.
module weight_skew_buffer #(
    parameter int unsigned COLS       = 4,
    parameter int unsigned W_BITWIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    weight_skew_buffer_if.slave  bus
);
    localparam int unsigned CW         = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW         = $clog2(DEPTH + 1);
    localparam int unsigned DW         = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DRAIN_LAST = (COLS > 1) ? COLS - 2 : 0;

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

    state_e                        r_state, w_state_nxt;
    logic [1:0]                    r_full, w_full_nxt;
    logic                          r_wr_bank, w_wr_bank_nxt;
    logic                          r_rd_bank, w_rd_bank_nxt;
    logic [LW-1:0]                 r_len, w_len_nxt;
    logic [LW-1:0]                 r_cnt, w_cnt_nxt;
    logic                          r_rev, w_rev_nxt;
    logic [DW-1:0]                 r_drain, w_drain_nxt;
    logic [COLS-1:0]               r_vld;
    logic [COLS-1:0][AW-1:0]       r_addr;
    logic                          w_vld0_nxt;
    logic [AW-1:0]                 w_addr0_nxt;

    logic [W_BITWIDTH-1:0]         r_mem [2][COLS][DEPTH];

    logic                          w_wr_ready;
    logic                          w_addr_ok;
    logic                          w_col_ok;
    logic                          w_wr_fire;
    logic                          w_commit_fire;
    logic                          w_start_ok;
    logic                          w_done_state;

    // Range checks collapse to constants when the index space is exactly a power of two.
    if ((1 << AW) == DEPTH) begin : g_addr_pow2
        assign w_addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign w_addr_ok = (bus.wr_addr < AW'(DEPTH));
    end

    if ((1 << CW) == COLS) begin : g_col_pow2
        assign w_col_ok = 1'b1;
    end else begin : g_col_chk
        assign w_col_ok = (bus.wr_col < CW'(COLS));
    end

    assign w_wr_ready    = ~r_full[r_wr_bank];
    assign w_wr_fire     = bus.wr_en & w_wr_ready & w_addr_ok & w_col_ok;
    assign w_commit_fire = bus.wr_commit & w_wr_ready;
    assign w_start_ok    = bus.start & r_full[r_rd_bank] & (bus.len != '0) &
                           (bus.len <= LW'(DEPTH));
    assign w_done_state  = (r_state == StDone);

    // Weight storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bank][bus.wr_col][bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        w_full_nxt    = r_full;
        w_wr_bank_nxt = r_wr_bank;
        if (w_commit_fire) begin
            w_full_nxt[r_wr_bank] = 1'b1;
            w_wr_bank_nxt         = ~r_wr_bank;
        end
        // Commit and DONE never target the same bank: one needs it empty, the other full.
        if (w_done_state) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_len_nxt     = r_len;
        w_rev_nxt     = r_rev;
        w_drain_nxt   = r_drain;
        w_rd_bank_nxt = r_rd_bank;
        w_vld0_nxt    = 1'b0;
        w_addr0_nxt   = r_addr[0];
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) begin
                    w_state_nxt = StStream;
                    w_vld0_nxt  = 1'b1;
                    w_cnt_nxt   = LW'(1);
                    w_len_nxt   = bus.len;
                    w_rev_nxt   = bus.rev;
                    w_addr0_nxt = bus.rev ? AW'(bus.len - LW'(1)) : '0;
                end
            end
            StStream: begin
                if (r_cnt == r_len) begin
                    w_state_nxt = (COLS > 1) ? StDrain : StDone;
                    w_drain_nxt = '0;
                end else begin
                    w_vld0_nxt  = 1'b1;
                    w_cnt_nxt   = r_cnt + LW'(1);
                    w_addr0_nxt = r_rev ? (r_addr[0] - AW'(1)) : (r_addr[0] + AW'(1));
                end
            end
            StDrain: begin
                // Hold until the last lane has replayed its final row.
                if (r_drain == DW'(DRAIN_LAST)) begin
                    w_state_nxt = StDone;
                end else begin
                    w_drain_nxt = r_drain + DW'(1);
                end
            end
            StDone: begin
                w_state_nxt   = StIdle;
                w_rd_bank_nxt = ~r_rd_bank;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= StIdle;
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_rev     <= 1'b0;
            r_drain   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_full    <= w_full_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_len     <= w_len_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rev     <= w_rev_nxt;
            r_drain   <= w_drain_nxt;
        end
    end

    // Skew pipeline: each lane carries lane 0's valid and row address, one cycle later per lane.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld  <= '0;
            r_addr <= '0;
        end else begin
            r_vld[0]  <= w_vld0_nxt;
            r_addr[0] <= w_addr0_nxt;
            for (int j = 1; j < COLS; j++) begin
                r_vld[j]  <= r_vld[j-1];
                r_addr[j] <= r_addr[j-1];
            end
        end
    end

    always_comb begin
        bus.o_data = '0;
        for (int j = 0; j < COLS; j++) begin
            if (r_vld[j]) begin
                bus.o_data[j] = r_mem[r_rd_bank][j][r_addr[j]];
            end
        end
    end

    assign bus.o_valid  = r_vld;
    assign bus.wr_ready = w_wr_ready;
    assign bus.busy     = (r_state != StIdle);
    assign bus.done     = w_done_state;

endmodule
